// File: rtl/mpu_pkg.sv
// Shared MPU types: matrix geometry, element/matrix typedefs and the
// result streamer state encoding.
package mpu_pkg;

    localparam int MATRIX_SIZE   = 5;
    localparam int ELEMENT_WIDTH = 8;
    localparam int IDX_W         = $clog2(MATRIX_SIZE);

    typedef logic [ELEMENT_WIDTH-1:0]                      element_t;
    typedef element_t [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0]   matrix_t;
    typedef logic [IDX_W-1:0]                              idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } streamer_state_e;

    localparam idx_t IDX_MAX = idx_t'(MATRIX_SIZE - 1);

    function automatic logic is_last_index(input idx_t row, input idx_t col);
        return (row == IDX_MAX) && (col == IDX_MAX);
    endfunction

endpackage

// File: rtl/mpu_result_streamer_if.sv
// Element stream leaving the result streamer, one matrix element per transfer.
interface mpu_result_streamer_if;
    import mpu_pkg::*;

    // A transfer happens on a rising edge where out_valid && out_ready. While
    // out_valid is high and out_ready low, every payload field holds stable;
    // out_valid never depends combinationally on out_ready.
    element_t out_data;
    logic     out_valid;
    logic     out_ready;
    logic     out_last;
    idx_t     out_row;
    idx_t     out_col;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_row,
        output out_col,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_row,
        input  out_col,
        output out_ready
    );

endinterface

// File: rtl/mpu_index_counter.sv
// Row-major row/col walker over a MATRIX_SIZE x MATRIX_SIZE matrix with a
// registered last flag; next_* expose the indices the registers will take.
module mpu_index_counter
    import mpu_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output idx_t row,
    output idx_t col,
    output logic last,
    output idx_t next_row,
    output idx_t next_col
);

    idx_t row_q, row_d;
    idx_t col_q, col_d;
    logic last_q, last_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (enable) begin
            if (col_q == IDX_MAX) begin
                col_d = '0;
                row_d = (row_q == IDX_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        last_d = is_last_index(row_d, col_d);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            row_q  <= '0;
            col_q  <= '0;
            last_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            last_q <= last_d;
        end
    end

    assign row      = row_q;
    assign col      = col_q;
    assign last     = last_q;
    assign next_row = row_d;
    assign next_col = col_d;

endmodule

// File: rtl/mpu_result_streamer.sv
// Snapshots the MPU result matrix on start and streams its 25 elements
// row-major over a valid/ready interface, pulsing done after the last one.
module mpu_result_streamer
    import mpu_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset_n,
    input  matrix_t                       matrix,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output streamer_state_e               dbg_state,
    mpu_result_streamer_if.master         strm
);

    streamer_state_e state_q, state_d;
    matrix_t         snap_q, snap_d;
    element_t        data_q, data_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            last_q, last_d;

    logic            xfer;
    logic            cnt_clear;
    logic            cnt_enable;
    logic            cnt_last;
    idx_t            row, col, next_row, next_col;

    assign xfer       = valid_q && strm.out_ready;
    assign cnt_clear  = (state_q == IDLE) && start;
    // The counter stays parked on [4][4] after the final transfer; the next
    // accepted start clears it.
    assign cnt_enable = (state_q == STREAM) && xfer && !cnt_last;

    mpu_index_counter u_index (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .row      (row),
        .col      (col),
        .last     (cnt_last),
        .next_row (next_row),
        .next_col (next_col)
    );

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = matrix;
                    data_d  = matrix[0][0];
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // Prefetch the next element into the output register so that
                // out_data is a flop, not a mux behind the index registers.
                if (xfer) begin
                    if (cnt_last) begin
                        state_d = DONE;
                    end else begin
                        data_d = snap_q[next_row][next_col];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d == STREAM);
        valid_d = (state_d == STREAM);
        done_d  = (state_d == DONE);
        last_d  = (state_d == STREAM) && is_last_index(next_row, next_col);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign dbg_state      = state_q;
    assign strm.out_data  = data_q;
    assign strm.out_valid = valid_q;
    assign strm.out_last  = last_q;
    assign strm.out_row   = row;
    assign strm.out_col   = col;

endmodule

// File: tb/tb_mpu_result_streamer.sv
// Scenario bench for mpu_result_streamer: expected elements are queued when a
// matrix is loaded and popped as the stream delivers them.
module tb_mpu_result_streamer;
    import mpu_pkg::*;

    logic            clock = 1'b0;
    logic            reset_n;
    matrix_t         mat;
    logic            start;
    logic            busy;
    logic            done;
    streamer_state_e dbg_state;

    mpu_result_streamer_if sif ();

    mpu_result_streamer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .matrix    (mat),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state),
        .strm      (sif.master)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    // {last, row, col, data}
    logic [14:0] exp_q[$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic matrix_t ramp();
        matrix_t r;
        for (int i = 0; i < MATRIX_SIZE; i++)
            for (int j = 0; j < MATRIX_SIZE; j++)
                r[i][j] = element_t'(i * MATRIX_SIZE + j);
        return r;
    endfunction

    function automatic matrix_t rand_matrix();
        matrix_t r;
        for (int i = 0; i < MATRIX_SIZE; i++)
            for (int j = 0; j < MATRIX_SIZE; j++)
                r[i][j] = element_t'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic push_matrix(input matrix_t m);
        for (int i = 0; i < MATRIX_SIZE; i++)
            for (int j = 0; j < MATRIX_SIZE; j++)
                exp_q.push_back({((i == MATRIX_SIZE-1) && (j == MATRIX_SIZE-1)) ? 1'b1 : 1'b0,
                                 3'(i), 3'(j), m[i][j]});
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0;
        sif.out_ready = 1'b0;
        mat = ramp();
        repeat (3) tick();
        checks++;
        if ({busy, done, sif.out_valid, sif.out_last} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/valid/last=%b required 0000",
                     {busy, done, sif.out_valid, sif.out_last});
        end
        checks++;
        if ({sif.out_data, sif.out_row, sif.out_col} !== 14'h0) begin
            errors++;
            $display("FAIL reset_payload: got data=%h row=%0d col=%0d required 0/0/0",
                     sif.out_data, sif.out_row, sif.out_col);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
        end
        reset_n = 1'b1;
        sif.out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, sif.out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL idle_no_start: got busy/valid=%b required 00", {busy, sif.out_valid});
        end
    endtask

    task automatic test_basic();
        int n;
        int xfers;
        logic [14:0] obs;
        logic [14:0] exp;
        mat = ramp();
        push_matrix(mat);
        sif.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        xfers = 0;
        while (n < 200) begin
            if (sif.out_valid && sif.out_ready) begin
                obs = {sif.out_last, sif.out_row, sif.out_col, sif.out_data};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL basic_extra: got %h required no element", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL basic_elem: got %h required %h", obs, exp);
                    end
                end
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_busy: got %b required 1", busy);
                end
                xfers++;
            end
            if (done === 1'b1) break;
            tick();
            n++;
        end
        checks++;
        if (n !== 26) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles required 26", n);
        end
        checks++;
        if (xfers !== 25 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_count: got %0d transfers required 25 (left %0d)", xfers, exp_q.size());
        end
        checks++;
        if ({busy, sif.out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL basic_done_flags: got busy/valid=%b required 00", {busy, sif.out_valid});
        end
        tick();
        checks++;
        if ({done, busy, sif.out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL basic_done_pulse: got done/busy/valid=%b required 000",
                     {done, busy, sif.out_valid});
        end
        exp_q.delete();
    endtask

    task automatic test_ready_toggle();
        int n;
        int xfers;
        logic stalled;
        logic [14:0] held;
        logic [14:0] obs;
        logic [14:0] exp;
        mat = ramp();
        push_matrix(mat);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        xfers = 0;
        stalled = 1'b0;
        held = '0;
        while (n < 300) begin
            sif.out_ready = ((n - 1) % 3 == 0);
            obs = {sif.out_last, sif.out_row, sif.out_col, sif.out_data};
            if (stalled && sif.out_valid) begin
                checks++;
                if (obs !== held) begin
                    errors++;
                    $display("FAIL toggle_hold: got %h required %h", obs, held);
                end
            end
            if (sif.out_valid && sif.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL toggle_extra: got %h required no element", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL toggle_elem: got %h required %h", obs, exp);
                    end
                end
                xfers++;
            end
            stalled = sif.out_valid && !sif.out_ready;
            held = obs;
            if (done === 1'b1) break;
            tick();
            n++;
        end
        checks++;
        if (xfers !== 25 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL toggle_count: got %0d transfers required 25 (left %0d)", xfers, exp_q.size());
        end
        tick();
        exp_q.delete();
    endtask

    task automatic test_snapshot();
        int n;
        int xfers;
        logic [14:0] obs;
        logic [14:0] exp;
        mat = ramp();
        push_matrix(mat);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < MATRIX_SIZE; i++)
            for (int j = 0; j < MATRIX_SIZE; j++)
                mat[i][j] = 8'hFF;
        n = 1;
        xfers = 0;
        while (n < 400) begin
            sif.out_ready = 1'($urandom_range(0, 1));
            if (sif.out_valid && sif.out_ready) begin
                obs = {sif.out_last, sif.out_row, sif.out_col, sif.out_data};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL snap_extra: got %h required no element", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL snap_elem: got %h required %h", obs, exp);
                    end
                end
                xfers++;
            end
            if (done === 1'b1) break;
            tick();
            n++;
        end
        checks++;
        if (xfers !== 25 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL snap_count: got %0d transfers required 25 (left %0d)", xfers, exp_q.size());
        end
        tick();
        exp_q.delete();
    endtask

    task automatic test_start_held();
        int n;
        int xfers;
        int done_cnt;
        int second_slot;
        logic prev_valid;
        logic [14:0] obs;
        logic [14:0] exp;
        mat = ramp();
        push_matrix(mat);
        push_matrix(mat);
        sif.out_ready = 1'b1;
        start = 1'b1;
        tick();
        n = 1;
        xfers = 0;
        done_cnt = 0;
        second_slot = -1;
        prev_valid = 1'b0;
        while (n < 300 && done_cnt < 2) begin
            start = (n < 40);
            if (sif.out_valid && !prev_valid && done_cnt == 1) second_slot = n;
            prev_valid = sif.out_valid;
            if (sif.out_valid && sif.out_ready) begin
                obs = {sif.out_last, sif.out_row, sif.out_col, sif.out_data};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL held_extra: got %h required no element", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL held_elem: got %h required %h", obs, exp);
                    end
                end
                xfers++;
            end
            if (done === 1'b1) done_cnt++;
            tick();
            n++;
        end
        start = 1'b0;
        repeat (4) tick();
        checks++;
        if (second_slot !== 28) begin
            errors++;
            $display("FAIL held_restart: got second stream at cycle %0d required 28", second_slot);
        end
        checks++;
        if (done_cnt !== 2 || xfers !== 50) begin
            errors++;
            $display("FAIL held_count: got %0d done/%0d transfers required 2/50", done_cnt, xfers);
        end
        checks++;
        if ({busy, sif.out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL held_idle: got busy/valid=%b required 00", {busy, sif.out_valid});
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        int n;
        int xfers;
        logic [14:0] obs;
        logic [14:0] exp;
        mat = rand_matrix();
        push_matrix(mat);
        sif.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        xfers = 0;
        while (n < 100 && xfers < 10) begin
            if (sif.out_valid && sif.out_ready) begin
                obs = {sif.out_last, sif.out_row, sif.out_col, sif.out_data};
                checks++;
                exp = exp_q.pop_front();
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL rst_elem: got %h required %h", obs, exp);
                end
                xfers++;
            end
            if (xfers < 10) begin
                tick();
                n++;
            end
        end
        tick();
        reset_n = 1'b0;
        tick();
        checks++;
        if ({busy, done, sif.out_valid, sif.out_last} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid_flags: got busy/done/valid/last=%b required 0000",
                     {busy, done, sif.out_valid, sif.out_last});
        end
        checks++;
        if ({sif.out_data, sif.out_row, sif.out_col} !== 14'h0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL rst_mid_payload: got data=%h row=%0d col=%0d state=%0d required 0/0/0/0",
                     sif.out_data, sif.out_row, sif.out_col, dbg_state);
        end
        reset_n = 1'b1;
        exp_q.delete();
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_done: got %b required 0", done);
        end
        mat = rand_matrix();
        push_matrix(mat);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        xfers = 0;
        while (n < 200) begin
            if (sif.out_valid && sif.out_ready) begin
                obs = {sif.out_last, sif.out_row, sif.out_col, sif.out_data};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rst_restart_extra: got %h required no element", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL rst_restart_elem: got %h required %h", obs, exp);
                    end
                end
                xfers++;
            end
            if (done === 1'b1) break;
            tick();
            n++;
        end
        checks++;
        if (xfers !== 25 || n !== 26) begin
            errors++;
            $display("FAIL rst_restart_count: got %0d transfers in %0d cycles required 25 in 26", xfers, n);
        end
        tick();
        exp_q.delete();
    endtask

    task automatic test_signed();
        int n;
        int xfers;
        logic [14:0] obs;
        logic [14:0] exp;
        mat = rand_matrix();
        mat[0][0] = 8'h80;
        mat[4][4] = 8'h7F;
        push_matrix(mat);
        sif.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (sif.out_data !== 8'h80) begin
            errors++;
            $display("FAIL signed_first: got %h required 80", sif.out_data);
        end
        n = 1;
        xfers = 0;
        while (n < 200) begin
            if (sif.out_valid && sif.out_ready) begin
                obs = {sif.out_last, sif.out_row, sif.out_col, sif.out_data};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL signed_extra: got %h required no element", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL signed_elem: got %h required %h", obs, exp);
                    end
                end
                xfers++;
            end
            if (done === 1'b1) break;
            tick();
            n++;
        end
        checks++;
        if (xfers !== 25 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL signed_count: got %0d transfers required 25 (left %0d)", xfers, exp_q.size());
        end
        tick();
        exp_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        sif.out_ready = 1'b0;
        mat = '0;
        test_reset();
        test_basic();
        test_ready_toggle();
        test_snapshot();
        test_start_held();
        test_reset_mid();
        test_signed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
